// File: rtl/id_ex_pipeline_register_if.sv
// ID/EX bundle: decoded operands, instruction word and control bits flowing
// from Decode into the ID/EX register, plus the registered copies that the
// register presents to Execute. Decode (or a bench) uses the master view. The
// pipeline register uses the slave view.
interface id_ex_pipeline_register_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    // Pipeline control from the hazard unit
    logic                  Stall;
    logic                  Flush;
    logic                  CountClr;

    // Decode-side values
    logic [DATA_WIDTH-1:0] ReadData1_In;
    logic [DATA_WIDTH-1:0] ReadData2_In;
    logic [DATA_WIDTH-1:0] Instruction_In;
    logic [DATA_WIDTH-1:0] Imm_Extended_In;
    logic [DATA_WIDTH-1:0] PCPlus4_In;
    logic [9:0]            Ctrl_In;  // {ALUSrc,RegDst,HiWrite,LoWrite,Madd,Msub,RegWrite,MemRead,MemWrite,MemToReg}

    // Execute-side registered values
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [DATA_WIDTH-1:0] Instruction;
    logic [DATA_WIDTH-1:0] Instruction_15_0_Extended;
    logic [DATA_WIDTH-1:0] PCPlus4;
    logic                  ALUSrc;
    logic                  RegDst;
    logic                  HiWrite;
    logic                  LoWrite;
    logic                  Madd;
    logic                  Msub;
    logic                  RegWrite;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  MemToReg;
    logic [4:0]            Rs;
    logic [4:0]            Rt;
    logic                  Valid;
    logic [CNT_WIDTH-1:0]  BubbleCount;

    modport master (
        output Stall, Flush, CountClr,
        output ReadData1_In, ReadData2_In, Instruction_In, Imm_Extended_In,
        output PCPlus4_In, Ctrl_In,
        input  ReadData1, ReadData2, Instruction, Instruction_15_0_Extended,
        input  PCPlus4, ALUSrc, RegDst, HiWrite, LoWrite, Madd, Msub,
        input  RegWrite, MemRead, MemWrite, MemToReg, Rs, Rt, Valid, BubbleCount
    );

    modport slave (
        input  Stall, Flush, CountClr,
        input  ReadData1_In, ReadData2_In, Instruction_In, Imm_Extended_In,
        input  PCPlus4_In, Ctrl_In,
        output ReadData1, ReadData2, Instruction, Instruction_15_0_Extended,
        output PCPlus4, ALUSrc, RegDst, HiWrite, LoWrite, Madd, Msub,
        output RegWrite, MemRead, MemWrite, MemToReg, Rs, Rt, Valid, BubbleCount
    );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register. Holds one decoded instruction for Execute, with
// hold (Stall) and bubble insertion (Flush, which wins over Stall). A Valid
// bit marks real instructions. A saturating counter records how many bubbles
// were inserted, for hazard profiling.
module id_ex_pipeline_register #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
    input logic                      Clk,
    input logic                      Rst,
    id_ex_pipeline_register_if.slave bus
);

    typedef struct packed {
        logic alu_src;
        logic reg_dst;
        logic hi_write;
        logic lo_write;
        logic madd;
        logic msub;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] read_data1;
        logic [DATA_WIDTH-1:0] read_data2;
        logic [DATA_WIDTH-1:0] instruction;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] pc_plus4;
        ctrl_t                 ctrl;
        logic                  valid;
    } stage_t;

    // A bubble has every control bit cleared, so it can never write a
    // register, memory, HI/LO or the MAC accumulator.
    localparam stage_t BUBBLE = '{
        read_data1:  '0,
        read_data2:  '0,
        instruction: NOP_INSTR,
        imm:         '0,
        pc_plus4:    '0,
        ctrl:        '0,
        valid:       1'b0
    };

    stage_t               stage_q;
    stage_t               load_d;
    logic [CNT_WIDTH-1:0] bubble_cnt_q;
    logic                 cnt_saturated;

    // Everything Decode offers this cycle, packed into one stage record
    assign load_d = '{
        read_data1:  bus.ReadData1_In,
        read_data2:  bus.ReadData2_In,
        instruction: bus.Instruction_In,
        imm:         bus.Imm_Extended_In,
        pc_plus4:    bus.PCPlus4_In,
        ctrl:        ctrl_t'(bus.Ctrl_In),
        valid:       1'b1
    };

    // Stage register: Flush loads a bubble, Stall holds, otherwise load
    always_ff @(posedge Clk or posedge Rst) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values; blocking here would create order-dependent simulation.
        if (Rst) begin
            stage_q <= BUBBLE;
        end else if (bus.Flush) begin
            stage_q <= BUBBLE;
        end else if (!bus.Stall) begin
            stage_q <= load_d;
        end
    end

    assign cnt_saturated = &bubble_cnt_q;

    // Bubble counter: clear wins over increment, and it sticks at all-ones
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bubble_cnt_q <= '0;
        end else if (bus.CountClr) begin
            bubble_cnt_q <= '0;
        end else if (bus.Flush && !cnt_saturated) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    // Registered values straight to Execute; no input reaches an output combinationally
    assign bus.ReadData1                 = stage_q.read_data1;
    assign bus.ReadData2                 = stage_q.read_data2;
    assign bus.Instruction               = stage_q.instruction;
    assign bus.Instruction_15_0_Extended = stage_q.imm;
    assign bus.PCPlus4                   = stage_q.pc_plus4;
    assign bus.ALUSrc                    = stage_q.ctrl.alu_src;
    assign bus.RegDst                    = stage_q.ctrl.reg_dst;
    assign bus.HiWrite                   = stage_q.ctrl.hi_write;
    assign bus.LoWrite                   = stage_q.ctrl.lo_write;
    assign bus.Madd                      = stage_q.ctrl.madd;
    assign bus.Msub                      = stage_q.ctrl.msub;
    assign bus.RegWrite                  = stage_q.ctrl.reg_write;
    assign bus.MemRead                   = stage_q.ctrl.mem_read;
    assign bus.MemWrite                  = stage_q.ctrl.mem_write;
    assign bus.MemToReg                  = stage_q.ctrl.mem_to_reg;
    assign bus.Valid                     = stage_q.valid;
    assign bus.BubbleCount               = bubble_cnt_q;

    // Forwarding-unit source fields come from the registered instruction
    assign bus.Rs = stage_q.instruction[25:21];
    assign bus.Rt = stage_q.instruction[20:16];

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed vectors with literal
// expectations, plus a slot-level reference model compared on every falling
// clock edge. A second instance with a 2-bit counter shares all inputs so that
// counter saturation can be observed.
module tb_id_ex_pipeline_register;

    localparam int DW = 32;

    logic clk;
    logic rst;

    id_ex_pipeline_register_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) bus ();
    id_ex_pipeline_register_if #(.DATA_WIDTH(DW), .CNT_WIDTH(2))  bus2 ();

    id_ex_pipeline_register #(.DATA_WIDTH(DW), .CNT_WIDTH(16), .NOP_INSTR(32'h0)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus.slave)
    );

    id_ex_pipeline_register #(.DATA_WIDTH(DW), .CNT_WIDTH(2), .NOP_INSTR(32'h0)) dut_cw2 (
        .Clk (clk),
        .Rst (rst),
        .bus (bus2.slave)
    );

    assign bus2.Stall           = bus.Stall;
    assign bus2.Flush           = bus.Flush;
    assign bus2.CountClr        = bus.CountClr;
    assign bus2.ReadData1_In    = bus.ReadData1_In;
    assign bus2.ReadData2_In    = bus.ReadData2_In;
    assign bus2.Instruction_In  = bus.Instruction_In;
    assign bus2.Imm_Extended_In = bus.Imm_Extended_In;
    assign bus2.PCPlus4_In      = bus.PCPlus4_In;
    assign bus2.Ctrl_In         = bus.Ctrl_In;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [9:0] dut_ctrl;
    assign dut_ctrl = {bus.ALUSrc, bus.RegDst, bus.HiWrite, bus.LoWrite, bus.Madd,
                       bus.Msub, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.MemToReg};

    // ------------------------------------------------------------------
    // Reference model: one "slot" holding whatever instruction Execute
    // should currently see, and two bubble tallies.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [9:0]  ctrl;
        logic        valid;
    } slot_t;

    localparam slot_t EMPTY_SLOT = '{rd1: 32'h0, rd2: 32'h0, instr: 32'h0, imm: 32'h0,
                                     pc4: 32'h0, ctrl: 10'h0, valid: 1'b0};

    slot_t m_slot;
    int    m_cnt;
    int    m_cnt2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_slot = EMPTY_SLOT;
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            if (bus.Flush)
                m_slot = EMPTY_SLOT;
            else if (!bus.Stall)
                m_slot = '{rd1: bus.ReadData1_In, rd2: bus.ReadData2_In, instr: bus.Instruction_In,
                           imm: bus.Imm_Extended_In, pc4: bus.PCPlus4_In, ctrl: bus.Ctrl_In,
                           valid: 1'b1};
            if (bus.CountClr) begin
                m_cnt  = 0;
                m_cnt2 = 0;
            end else if (bus.Flush) begin
                m_cnt  = (m_cnt  >= 65535) ? 65535 : m_cnt + 1;
                m_cnt2 = (m_cnt2 >= 3)     ? 3     : m_cnt2 + 1;
            end
        end
    end

    // Compare process: every falling edge, DUT against model
    always @(negedge clk) begin
        check("cmp_rd1",   64'(bus.ReadData1),                 64'(m_slot.rd1));
        check("cmp_rd2",   64'(bus.ReadData2),                 64'(m_slot.rd2));
        check("cmp_instr", 64'(bus.Instruction),               64'(m_slot.instr));
        check("cmp_imm",   64'(bus.Instruction_15_0_Extended), 64'(m_slot.imm));
        check("cmp_pc4",   64'(bus.PCPlus4),                   64'(m_slot.pc4));
        check("cmp_ctrl",  64'(dut_ctrl),                      64'(m_slot.ctrl));
        check("cmp_rs",    64'(bus.Rs),                        64'(m_slot.instr[25:21]));
        check("cmp_rt",    64'(bus.Rt),                        64'(m_slot.instr[20:16]));
        check("cmp_valid", 64'(bus.Valid),                     64'(m_slot.valid));
        check("cmp_cnt",   64'(bus.BubbleCount),               64'(m_cnt));
        check("cmp_cnt2",  64'(bus2.BubbleCount),              64'(m_cnt2));
        check("cmp_valid2", 64'(bus2.Valid),                   64'(m_slot.valid));
        if (!bus.Valid)
            check("bubble_inv", 64'({bus.HiWrite, bus.LoWrite, bus.Madd, bus.Msub,
                                     bus.RegWrite, bus.MemRead, bus.MemWrite}), 64'(0));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after a rising edge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [31:0] instr, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [31:0] imm,
                          input logic [31:0] pc4, input logic [9:0] ctrl);
        bus.Instruction_In  = instr;
        bus.ReadData1_In    = rd1;
        bus.ReadData2_In    = rd2;
        bus.Imm_Extended_In = imm;
        bus.PCPlus4_In      = pc4;
        bus.Ctrl_In         = ctrl;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_instr"}, 64'(bus.Instruction), 64'h0);
        check({tag, "_rd1"},   64'(bus.ReadData1),   64'h0);
        check({tag, "_pc4"},   64'(bus.PCPlus4),     64'h0);
        check({tag, "_ctrl"},  64'(dut_ctrl),        64'h0);
        check({tag, "_valid"}, 64'(bus.Valid),       64'h0);
        check({tag, "_cnt"},   64'(bus.BubbleCount), 64'h0);
        check({tag, "_cnt2"},  64'(bus2.BubbleCount), 64'h0);
    endtask

    int exp_cw2 [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst          = 1'b1;
        bus.Stall    = 1'b0;
        bus.Flush    = 1'b0;
        bus.CountClr = 1'b0;
        set_in(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0);
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b0;

        // Plain load: one-cycle latency, Rs/Rt decoded from the registered word
        set_in(32'h012A4020, 32'd5, 32'd7, 32'h0000_4020, 32'h0000_0104, 10'b0100001000);
        tick();
        check("load_instr",  64'(bus.Instruction), 64'h012A4020);
        check("load_rs",     64'(bus.Rs),          64'd9);
        check("load_rt",     64'(bus.Rt),          64'd10);
        check("load_regdst", 64'(bus.RegDst),      64'd1);
        check("load_regwr",  64'(bus.RegWrite),    64'd1);
        check("load_alusrc", 64'(bus.ALUSrc),      64'd0);
        check("load_rd1",    64'(bus.ReadData1),   64'd5);
        check("load_pc4",    64'(bus.PCPlus4),     64'h104);
        check("load_valid",  64'(bus.Valid),       64'd1);

        // Stall for three cycles while Decode keeps changing
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(32'hFFFF_0000 + 32'(i), 32'hDEAD_0000 + 32'(i), 32'(i), 32'(i), 32'(i), 10'h3FF);
            tick();
            check("stall_instr", 64'(bus.Instruction), 64'h012A4020);
            check("stall_rd1",   64'(bus.ReadData1),   64'd5);
            check("stall_ctrl",  64'(dut_ctrl),        64'h108);
            check("stall_valid", 64'(bus.Valid),       64'd1);
        end

        // Flush together with Stall: the bubble wins
        bus.Flush = 1'b1;
        tick();
        check("flush_valid", 64'(bus.Valid),        64'd0);
        check("flush_ctrl",  64'(dut_ctrl),         64'h0);
        check("flush_instr", 64'(bus.Instruction),  64'h0);
        check("flush_rd1",   64'(bus.ReadData1),    64'h0);
        check("flush_cnt",   64'(bus.BubbleCount),  64'd1);
        check("flush_cnt2",  64'(bus2.BubbleCount), 64'd1);

        // Counter: clear, then five flushes (2-bit copy saturates at 3)
        bus.Stall    = 1'b0;
        bus.Flush    = 1'b0;
        bus.CountClr = 1'b1;
        tick();
        check("clr_cnt",  64'(bus.BubbleCount),  64'd0);
        check("clr_cnt2", 64'(bus2.BubbleCount), 64'd0);
        bus.CountClr = 1'b0;
        bus.Flush    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_cnt",  64'(bus.BubbleCount),  64'(i + 1));
            check("sat_cnt2", 64'(bus2.BubbleCount), 64'(exp_cw2[i]));
        end
        bus.CountClr = 1'b1;
        tick();
        check("clr_over_inc_cnt",  64'(bus.BubbleCount),  64'd0);
        check("clr_over_inc_cnt2", 64'(bus2.BubbleCount), 64'd0);
        bus.CountClr = 1'b0;

        // Asynchronous reset in the middle of a stall
        tick();
        bus.Flush = 1'b0;
        set_in(32'h0232_8820, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_8820, 32'h0000_0200, 10'b0000001001);
        tick();
        check("pre_rst_valid", 64'(bus.Valid),       64'd1);
        check("pre_rst_cnt",   64'(bus.BubbleCount), 64'd1);
        bus.Stall = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        set_in(32'h0400_0001, 32'd9, 32'd9, 32'd9, 32'd9, 10'h3FF);
        bus.Stall = 1'b0;
        tick();
        tick();
        check_reset_state("rst_held");
        rst       = 1'b0;
        tick();
        check("post_rst_instr", 64'(bus.Instruction), 64'h0400_0001);
        check("post_rst_valid", 64'(bus.Valid),       64'd1);
        check("post_rst_cnt",   64'(bus.BubbleCount), 64'd0);

        // Random mix of stall / flush / clear / load / occasional reset
        for (int n = 0; n < 300; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            bus.Stall    = ($urandom_range(0, 3) == 0);
            bus.Flush    = ($urandom_range(0, 4) == 0);
            bus.CountClr = ($urandom_range(0, 39) == 0);
            set_in($urandom, $urandom, $urandom, $urandom, $urandom, 10'($urandom));
            tick();
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
